// File: rtl/text_console_writer_if.sv
// Byte-stream input and screen-buffer write port of the text console writer.
// Stream side is valid/ready; the write port is a plain registered strobe with address and data.
interface text_console_writer_if #(
   parameter int ADDR_WIDTH = 10
) ();
   logic                  s_valid;
   logic [7:0]            s_data;
   logic                  s_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [6:0]            mem_wdata;

   modport master (
      output s_valid, s_data,
      input  s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: ASCII bytes in, font indices written at the cursor; write lands one cycle after acceptance.
// s_ready is high only in IDLE; full-screen and new-line clears stall the stream until the last blank is written.
module text_console_writer #(
   parameter int CHAR_COLUMNS = 60,
   parameter int CHAR_ROWS    = 17,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   text_console_writer_if.slave   bus,
   output logic [6:0]             cursor_x,
   output logic [4:0]             cursor_y,
   output logic                   busy
);
   localparam int CLR_W = ADDR_WIDTH + 1;
   localparam logic [CLR_W-1:0]      CLR_TOTAL = CLR_W'(CHAR_COLUMNS * CHAR_ROWS);
   localparam logic [6:0]            COL_LAST  = 7'(CHAR_COLUMNS - 1);
   localparam logic [6:0]            COL_COUNT = 7'(CHAR_COLUMNS);
   localparam logic [4:0]            ROW_LAST  = 5'(CHAR_ROWS - 1);
   localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(CHAR_COLUMNS);

   typedef enum logic [1:0] {
      CLR_ALL  = 2'd0,
      IDLE     = 2'd1,
      CLR_LINE = 2'd2
   } state_t;

   state_t                state;
   logic [CLR_W-1:0]      clr_cnt;
   logic [6:0]            line_cnt;
   logic [6:0]            col;
   logic [4:0]            row;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [6:0]            mem_wdata;

   logic [4:0]            next_row;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] next_base;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] bs_addr;
   logic                  printable;

   assign bus.s_ready   = (state == IDLE);
   assign busy          = (state != IDLE);
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign cursor_x      = col;
   assign cursor_y      = row;

   always_comb begin
      next_row  = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
      row_base  = ADDR_WIDTH'(row) * COLS_A;
      next_base = ADDR_WIDTH'(next_row) * COLS_A;
      cur_addr  = row_base + ADDR_WIDTH'(col);
      bs_addr   = row_base + ADDR_WIDTH'(col - 7'd1);
      printable = (bus.s_data >= 8'h20) && (bus.s_data <= 8'h7E);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLR_ALL;
         clr_cnt   <= '0;
         line_cnt  <= '0;
         col       <= '0;
         row       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            // Leave a clear state only after its last blank has been on the bus for a cycle.
            CLR_ALL: begin
               if (clr_cnt == CLR_TOTAL) begin
                  mem_we <= 1'b0;
                  col    <= '0;
                  row    <= '0;
                  state  <= IDLE;
               end else begin
                  mem_we    <= 1'b1;
                  mem_addr  <= clr_cnt[ADDR_WIDTH-1:0];
                  mem_wdata <= '0;
                  clr_cnt   <= clr_cnt + 1'b1;
               end
            end
            CLR_LINE: begin
               if (line_cnt == COL_COUNT) begin
                  mem_we <= 1'b0;
                  state  <= IDLE;
               end else begin
                  mem_we    <= 1'b1;
                  mem_addr  <= row_base + ADDR_WIDTH'(line_cnt);
                  mem_wdata <= '0;
                  line_cnt  <= line_cnt + 7'd1;
               end
            end
            IDLE: begin
               mem_we <= 1'b0;
               if (bus.s_valid) begin
                  if (printable) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= cur_addr;
                     mem_wdata <= 7'(bus.s_data - 8'h20);
                     // A wrapping character writes first, then the new row is blanked from column 0.
                     if (col == COL_LAST) begin
                        col      <= '0;
                        row      <= next_row;
                        line_cnt <= '0;
                        state    <= CLR_LINE;
                     end else begin
                        col <= col + 7'd1;
                     end
                  end else begin
                     case (bus.s_data)
                        8'h0A: begin
                           col       <= '0;
                           row       <= next_row;
                           mem_we    <= 1'b1;
                           mem_addr  <= next_base;
                           mem_wdata <= '0;
                           line_cnt  <= 7'd1;
                           state     <= CLR_LINE;
                        end
                        8'h0D: col <= '0;
                        8'h08: begin
                           if (col != 7'd0) begin
                              col       <= col - 7'd1;
                              mem_we    <= 1'b1;
                              mem_addr  <= bs_addr;
                              mem_wdata <= '0;
                           end
                        end
                        8'h0C: begin
                           col       <= '0;
                           row       <= '0;
                           mem_we    <= 1'b1;
                           mem_addr  <= '0;
                           mem_wdata <= '0;
                           clr_cnt   <= CLR_W'(1);
                           state     <= CLR_ALL;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: begin
               mem_we  <= 1'b0;
               clr_cnt <= '0;
               state   <= CLR_ALL;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with an 8x2 character screen.
// Single-byte cases come from a vector table; wrap, line feed, form feed and reset are hand sequences.
module tb_text_console_writer;
   localparam int COLS = 8;
   localparam int ROWS = 2;
   localparam int AW   = 4;

   logic       clk;
   logic       rst_n;
   logic [6:0] cursor_x;
   logic [4:0] cursor_y;
   logic       busy;
   int         checks;
   int         errors;

   text_console_writer_if #(.ADDR_WIDTH(AW)) bus ();

   text_console_writer #(
      .CHAR_COLUMNS (COLS),
      .CHAR_ROWS    (ROWS),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .cursor_x (cursor_x),
      .cursor_y (cursor_y),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dat;
      logic       exp_we;
      int         exp_addr;
      int         exp_wdata;
      int         exp_x;
      int         exp_y;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic exp_wr(input string tag, input int addr, input int wdata);
      chk({tag, "_we"}, int'(bus.mem_we), 1);
      chk({tag, "_addr"}, int'(bus.mem_addr), addr);
      chk({tag, "_wdata"}, int'(bus.mem_wdata), wdata);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      @(negedge clk);
      bus.s_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;

      vecs[0]  = '{8'h0D, 1'b0, 0, 0,    0, 0};
      vecs[1]  = '{8'h41, 1'b1, 0, 8'h21, 1, 0};
      vecs[2]  = '{8'h07, 1'b0, 0, 0,    1, 0};
      vecs[3]  = '{8'h08, 1'b1, 0, 0,    0, 0};
      vecs[4]  = '{8'h08, 1'b0, 0, 0,    0, 0};
      vecs[5]  = '{8'h20, 1'b1, 0, 0,    1, 0};
      vecs[6]  = '{8'h7E, 1'b1, 1, 8'h5E, 2, 0};
      vecs[7]  = '{8'h7F, 1'b0, 0, 0,    2, 0};
      vecs[8]  = '{8'hFF, 1'b0, 0, 0,    2, 0};
      vecs[9]  = '{8'h7A, 1'b1, 2, 8'h5A, 3, 0};
      vecs[10] = '{8'h08, 1'b1, 2, 0,    2, 0};
      vecs[11] = '{8'h00, 1'b0, 0, 0,    2, 0};
      vecs[12] = '{8'h0D, 1'b0, 0, 0,    0, 0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_we", int'(bus.mem_we), 0);
      chk("rst_addr", int'(bus.mem_addr), 0);
      chk("rst_wdata", int'(bus.mem_wdata), 0);
      chk("rst_ready", int'(bus.s_ready), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_x", int'(cursor_x), 0);
      chk("rst_y", int'(cursor_y), 0);

      // Power-on clear of all 16 cells
      rst_n = 1'b1;
      for (int i = 0; i < COLS * ROWS; i++) begin
         @(negedge clk);
         exp_wr($sformatf("init_clr%0d", i), i, 0);
         chk($sformatf("init_busy%0d", i), int'(busy), 1);
      end
      @(negedge clk);
      chk("init_done_we", int'(bus.mem_we), 0);
      chk("init_done_ready", int'(bus.s_ready), 1);
      chk("init_done_x", int'(cursor_x), 0);
      chk("init_done_y", int'(cursor_y), 0);

      // "AB" back to back
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h41;
      @(negedge clk);
      exp_wr("ab_a", 0, 8'h21);
      chk("ab_ready", int'(bus.s_ready), 1);
      bus.s_data = 8'h42;
      @(negedge clk);
      bus.s_valid = 1'b0;
      exp_wr("ab_b", 1, 8'h22);
      chk("ab_x", int'(cursor_x), 2);

      // Single-byte vector table
      for (int i = 0; i < 13; i++) begin
         send_byte(vecs[i].dat);
         chk($sformatf("vec%0d_we", i), int'(bus.mem_we), int'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_addr", i), int'(bus.mem_addr), vecs[i].exp_addr);
            chk($sformatf("vec%0d_wdata", i), int'(bus.mem_wdata), vecs[i].exp_wdata);
         end
         chk($sformatf("vec%0d_x", i), int'(cursor_x), vecs[i].exp_x);
         chk($sformatf("vec%0d_y", i), int'(cursor_y), vecs[i].exp_y);
         chk($sformatf("vec%0d_ready", i), int'(bus.s_ready), 1);
      end

      // Eight 'A' from column 0: last one wraps and blanks row 1
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h41;
      for (int k = 0; k < COLS; k++) begin
         @(negedge clk);
         exp_wr($sformatf("wrap_chr%0d", k), k, 8'h21);
      end
      chk("wrap_ready_chr", int'(bus.s_ready), 0);
      chk("wrap_x", int'(cursor_x), 0);
      chk("wrap_y", int'(cursor_y), 1);
      bus.s_data = 8'h51;
      for (int j = 0; j < COLS; j++) begin
         @(negedge clk);
         exp_wr($sformatf("wrap_clr%0d", j), COLS + j, 0);
         chk($sformatf("wrap_ready%0d", j), int'(bus.s_ready), 0);
      end
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("wrap_done_we", int'(bus.mem_we), 0);
      chk("wrap_done_ready", int'(bus.s_ready), 1);
      chk("wrap_done_x", int'(cursor_x), 0);

      // LF on the last row wraps to row 0 and blanks it
      send_byte(8'h0A);
      chk("lf_x", int'(cursor_x), 0);
      chk("lf_y", int'(cursor_y), 0);
      exp_wr("lf_clr0", 0, 0);
      for (int j = 1; j < COLS; j++) begin
         @(negedge clk);
         exp_wr($sformatf("lf_clr%0d", j), j, 0);
         chk($sformatf("lf_ready%0d", j), int'(bus.s_ready), 0);
      end
      @(negedge clk);
      chk("lf_done_we", int'(bus.mem_we), 0);
      chk("lf_done_ready", int'(bus.s_ready), 1);

      // Form feed mid-line
      send_byte(8'h41);
      send_byte(8'h42);
      chk("ff_pre_x", int'(cursor_x), 2);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h0C;
      for (int i = 0; i < COLS * ROWS; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
         exp_wr($sformatf("ff_clr%0d", i), i, 0);
         chk($sformatf("ff_busy%0d", i), int'(busy), 1);
      end
      chk("ff_x", int'(cursor_x), 0);
      chk("ff_y", int'(cursor_y), 0);
      @(negedge clk);
      chk("ff_done_busy", int'(busy), 0);
      chk("ff_done_we", int'(bus.mem_we), 0);

      // Reset asserted during a line clear
      send_byte(8'h0A);
      exp_wr("rlf_clr0", COLS, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", int'(bus.mem_we), 0);
      chk("mid_rst_addr", int'(bus.mem_addr), 0);
      chk("mid_rst_busy", int'(busy), 1);
      chk("mid_rst_ready", int'(bus.s_ready), 0);
      chk("mid_rst_y", int'(cursor_y), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < COLS * ROWS; i++) begin
         @(negedge clk);
         exp_wr($sformatf("re_clr%0d", i), i, 0);
      end
      @(negedge clk);
      chk("re_done_ready", int'(bus.s_ready), 1);
      chk("re_done_we", int'(bus.mem_we), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
